// File: rtl/sblock_cfg.sv
// Parametrised W-track switch block with a chainable serial config scan path,
// shadow/active double buffering and atomic commit. Define SBLOCK_OUT_REG_EN to register the outputs.
module sblock_cfg #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [W-1:0] left_i,
    input  logic [W-1:0] up_i,
    output logic [W-1:0] right_o,
    output logic [W-1:0] down_o,
    input  logic         cfg_shift_i,
    input  logic         cfg_data_i,
    output logic         cfg_data_o,
    input  logic         cfg_commit_i,
    output logic         cfg_ready_o,
    output logic         cfg_err_o
);
    localparam int SEL_W    = $clog2(2*W+1);
    localparam int CFG_BITS = 2*W*SEL_W;
    localparam int CNT_W    = $clog2(CFG_BITS+1);
    localparam int SRC_W    = 1 << SEL_W;

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                commit_ok;

    always_comb begin
        commit_ok = cfg_commit_i && ready_q && !cfg_shift_i;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        if (cfg_shift_i) begin
            shadow_d = {cfg_data_i, shadow_q[CFG_BITS-1:1]};
            if (cnt_q != CNT_W'(CFG_BITS))
                cnt_d = cnt_q + 1'b1;
        end
        if (commit_ok) begin
            active_d = shadow_q;
            cnt_d    = '0;
        end
        ready_d = (cnt_d == CNT_W'(CFG_BITS));
        err_d   = err_q || (cfg_commit_i && !commit_ok);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign cfg_data_o  = shadow_q[0];
    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = err_q;

    // Source index 0 and anything above 2W select the zero-padding bits.
    logic [SRC_W-1:0] src;
    logic [W-1:0]     right_c, down_c;
    assign src = {{(SRC_W-2*W-1){1'b0}}, up_i, left_i, 1'b0};

    for (genvar gi = 0; gi < W; gi++) begin : g_route
        logic [SEL_W-1:0] sel_r, sel_d;
        assign sel_r       = active_q[gi*SEL_W +: SEL_W];
        assign sel_d       = active_q[W*SEL_W + gi*SEL_W +: SEL_W];
        assign right_c[gi] = src[sel_r];
        assign down_c[gi]  = src[sel_d];
    end

`ifdef SBLOCK_OUT_REG_EN
    logic [W-1:0] right_q, down_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            right_q <= '0;
            down_q  <= '0;
        end else begin
            right_q <= right_c;
            down_q  <= down_c;
        end
    end
    assign right_o = right_q;
    assign down_o  = down_q;
`else
    assign right_o = right_c;
    assign down_o  = down_c;
`endif

endmodule

// File: tb/tb_sblock_cfg.sv
// Directed test of sblock_cfg: load/commit, rejected commits, illegal selects,
// two-tile chaining and mid-load reset.
module tb_sblock_cfg;
    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [2:0] left_i, up_i;
    logic [2:0] right0, down0, right1, down1;
    logic       shift0, shift1, data_i, commit0, commit1;
    logic       dout0, dout1, ready0, ready1, err0, err1;

    int checks = 0;
    int passed = 0;

    localparam logic [17:0] STRAIGHT = 18'h358D1;
    localparam logic [17:0] SWAP     = 18'h1A3AC;
    localparam logic [17:0] ILLEGAL  = 18'h3FFFF;

    always #5 clk_i = ~clk_i;

    sblock_cfg #(.W(3)) u0 (
        .clk_i(clk_i), .reset_i(reset_i), .left_i(left_i), .up_i(up_i),
        .right_o(right0), .down_o(down0), .cfg_shift_i(shift0), .cfg_data_i(data_i),
        .cfg_data_o(dout0), .cfg_commit_i(commit0), .cfg_ready_o(ready0), .cfg_err_o(err0)
    );

    sblock_cfg #(.W(3)) u1 (
        .clk_i(clk_i), .reset_i(reset_i), .left_i(left_i), .up_i(up_i),
        .right_o(right1), .down_o(down1), .cfg_shift_i(shift1), .cfg_data_i(dout0),
        .cfg_data_o(dout1), .cfg_commit_i(commit1), .cfg_ready_o(ready1), .cfg_err_o(err1)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Extra cycle for the routing result to reach registered outputs.
    task automatic settle();
`ifdef SBLOCK_OUT_REG_EN
        tick();
`endif
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Shift w[first +: n] LSB-first; sh selects which tile(s) shift.
    task automatic shift_bits(input logic [35:0] w, input int first, input int n,
                              input logic [1:0] sh);
        for (int i = first; i < first + n; i++) begin
            data_i = w[i];
            shift0 = sh[0];
            shift1 = sh[1];
            tick();
        end
        shift0 = 1'b0;
        shift1 = 1'b0;
    endtask

    task automatic commit_both(input logic c0, input logic c1);
        commit0 = c0;
        commit1 = c1;
        tick();
        commit0 = 1'b0;
        commit1 = 1'b0;
        settle();
    endtask

    initial begin
        reset_i = 1'b1; left_i = 3'b111; up_i = 3'b111;
        shift0 = 0; shift1 = 0; data_i = 0; commit0 = 0; commit1 = 0;

        // 1: reset state
        tick(); tick();
        reset_i = 1'b0;
        tick();
        chk("rst_right", 8'(right0), 8'h0);
        chk("rst_down", 8'(down0), 8'h0);
        chk("rst_ready", 8'(ready0), 8'h0);
        chk("rst_err", 8'(err0), 8'h0);
        chk("rst_dout", 8'(dout0), 8'h0);

        // 2: straight routing
        left_i = 3'b101; up_i = 3'b011;
        shift_bits(36'(STRAIGHT), 0, 17, 2'b01);
        chk("ready_at17", 8'(ready0), 8'h0);
        shift_bits(36'(STRAIGHT), 17, 1, 2'b01);
        chk("ready_at18", 8'(ready0), 8'h1);
        commit_both(1'b1, 1'b0);
        chk("str_right", 8'(right0), 8'h5);
        chk("str_down", 8'(down0), 8'h3);
        chk("str_ready", 8'(ready0), 8'h0);
        chk("str_err", 8'(err0), 8'h0);

        // 3: swap routing, outputs hold during the load
        shift_bits(36'(SWAP), 0, 9, 2'b01);
        chk("hold_right", 8'(right0), 8'h5);
        chk("hold_down", 8'(down0), 8'h3);
        shift_bits(36'(SWAP), 9, 9, 2'b01);
        commit_both(1'b1, 1'b0);
        chk("swap_right", 8'(right0), 8'h3);
        chk("swap_down", 8'(down0), 8'h5);

        // 4: early commit rejected, later commit accepted
        shift_bits(36'(STRAIGHT), 0, 10, 2'b01);
        commit_both(1'b1, 1'b0);
        chk("early_err", 8'(err0), 8'h1);
        chk("early_right", 8'(right0), 8'h3);
        chk("early_down", 8'(down0), 8'h5);
        chk("early_ready", 8'(ready0), 8'h0);
        shift_bits(36'(STRAIGHT), 10, 8, 2'b01);
        chk("late_ready", 8'(ready0), 8'h1);
        commit_both(1'b1, 1'b0);
        chk("late_right", 8'(right0), 8'h5);
        chk("late_down", 8'(down0), 8'h3);
        chk("late_err", 8'(err0), 8'h1);

        // 5: illegal select values drive zero
        left_i = 3'b111; up_i = 3'b111;
        shift_bits(36'(ILLEGAL), 0, 18, 2'b01);
        commit_both(1'b1, 1'b0);
        chk("ill_right", 8'(right0), 8'h0);
        chk("ill_down", 8'(down0), 8'h0);

        // 6a: chain; first 18 bits sent end up in the downstream tile
        left_i = 3'b101; up_i = 3'b011;
        shift_bits({SWAP, STRAIGHT}, 0, 36, 2'b11);
        chk("chain_rdy0", 8'(ready0), 8'h1);
        chk("chain_rdy1", 8'(ready1), 8'h1);
        commit_both(1'b1, 1'b1);
        chk("up_right", 8'(right0), 8'h3);
        chk("up_down", 8'(down0), 8'h5);
        chk("dn_right", 8'(right1), 8'h5);
        chk("dn_down", 8'(down1), 8'h3);
        chk("dn_err", 8'(err1), 8'h0);

        // 6b: commit together with shift is rejected even when ready
        shift_bits(36'h0, 0, 18, 2'b10);
        chk("sim_ready", 8'(ready1), 8'h1);
        shift1 = 1'b1; commit1 = 1'b1;
        tick();
        shift1 = 1'b0; commit1 = 1'b0;
        settle();
        chk("sim_err", 8'(err1), 8'h1);
        chk("sim_right", 8'(right1), 8'h5);
        chk("sim_down", 8'(down1), 8'h3);
        chk("sim_ready2", 8'(ready1), 8'h1);

        // 6c: reset in the middle of a load
        shift_bits(36'(STRAIGHT), 0, 5, 2'b01);
        shift0 = 1'b1; data_i = 1'b1; reset_i = 1'b1;
        tick();
        shift0 = 1'b0; reset_i = 1'b0;
        chk("mid_ready", 8'(ready0), 8'h0);
        chk("mid_right", 8'(right0), 8'h0);
        chk("mid_down", 8'(down0), 8'h0);
        chk("mid_err0", 8'(err0), 8'h0);
        chk("mid_err1", 8'(err1), 8'h0);
        chk("mid_dout", 8'(dout0), 8'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sblock_cfg.md
Name: sblock_cfg

Overview:
- Parametrised successor to the fixed 3-track switch block. Routes W-bit horizontal and vertical track inputs (left_i, up_i) onto W-bit outputs (right_o, down_o) through a per-output-bit source mux.
- Configuration is loaded by a serial, chainable scan path into a shadow register and applied atomically by a commit strobe. Tiles can be daisy-chained, and a live routing image is never half-written.

Parameters:
- W, 3, tracks per side.
- SEL_W (localparam), $clog2(2*W+1), select-field width per output bit.
- CFG_BITS (localparam), 2*W*SEL_W, total configuration bits (18 at W=3).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- left_i  in  W  horizontal track inputs.
- up_i  in  W  vertical track inputs.
- right_o  out  W  horizontal track outputs.
- down_o  out  W  vertical track outputs.
- cfg_shift_i  in  1  shift enable for the scan chain.
- cfg_data_i  in  1  serial config bit in.
- cfg_data_o  out  1  serial config bit out, equal to shadow[0]; feeds the next tile.
- cfg_commit_i  in  1  copy shadow into active config.
- cfg_ready_o  out  1  shadow holds a complete image.
- cfg_err_o  out  1  sticky: a commit was rejected.

Behaviour:
- Reset (synchronous, on clk_i edge with reset_i=1):
  - shadow=0, active=0, bit counter=0.
  - cfg_ready_o=0, cfg_err_o=0.
  - right_o=down_o=0, because every select field is 0.
- Shift: on each cycle with cfg_shift_i=1, shadow <= {cfg_data_i, shadow[CFG_BITS-1:1]}.
  - Bits are sent LSB-first: after CFG_BITS shifts, the first bit sent sits in shadow[0].
- Bit counter:
  - Increments on every shift and saturates at CFG_BITS.
  - cfg_ready_o = (counter == CFG_BITS), registered.
  - Shifts past saturation keep shifting; ready stays 1, since the last CFG_BITS bits form a valid image.
- Commit: cfg_commit_i=1 with cfg_ready_o=1 and cfg_shift_i=0:
  - active <= shadow, counter <= 0, ready <= 0 on that edge.
  - The new routing is visible from the next cycle.
- Rejected commit: cfg_commit_i=1 with ready=0, or in the same cycle as cfg_shift_i=1:
  - active is unchanged and cfg_err_o is set.
  - Shift still takes effect if asserted. cfg_err_o clears only on reset.
- Field layout:
  - right_o[j] uses active[j*SEL_W +: SEL_W].
  - down_o[j] uses active[W*SEL_W + j*SEL_W +: SEL_W].
- Select decode for field value s:
  - s=0: drive 0.
  - 1..W: left_i[s-1].
  - W+1..2W: up_i[s-W-1].
  - s>2W: drive 0 (illegal value, no error flag).
- Routing path: combinational from left_i/up_i/active to outputs, with zero latency.
- Reset in mid-load discards the partial shadow image and the active config.

Optional Feature:
- Macro: SBLOCK_OUT_REG_EN.
- Defined: right_o and down_o are registered on clk_i.
  - One cycle of latency from inputs or a commit to the outputs.
  - Output registers reset to 0.
- Undefined: outputs are purely combinational as above.

Test Plan:
1. Reset then idle, W=3, left_i=3'b111, up_i=3'b111 -> right_o=000, down_o=000, cfg_ready_o=0, cfg_err_o=0.
2. Straight routing: shift 18'h358D1 LSB-first (18 cycles), then commit; left_i=3'b101, up_i=3'b011.
   - cfg_ready_o=1 after the 18th shift.
   - right_o=101, down_o=011 the cycle after commit.
   - cfg_ready_o=0 after commit.
3. Swap routing: shift 18'h1A3AC, then commit; left_i=3'b101, up_i=3'b011 -> right_o=011, down_o=101.
   - Outputs hold the straight pattern during the shift window.
4. Early commit after 10 shifts -> active unchanged, cfg_err_o=1 (stays 1). Completing 8 more shifts then committing succeeds, with err still 1.
5. Illegal select: all fields = 3'b111 (18'h3FFFF), commit, any inputs -> right_o=000, down_o=000.
6. Chaining plus simultaneous events:
   - Two instances chained through cfg_data_o; shift 36 bits; the first 18 sent land in the downstream tile.
   - Commit asserted together with cfg_shift_i -> rejected, err=1.
   - Reset asserted mid-shift -> ready=0, outputs 0 next cycle.
   - With SBLOCK_OUT_REG_EN, scenario 2 outputs appear one cycle later.
